// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word array with byte-lane writes, optional wait
// states on OKAY transfers and the two-cycle ERROR response.
module ahb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk_i,
    input  logic                  hresetn_i,
    input  logic                  hselx_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hbrust_i,
    input  logic [3:0]            hport_i,
    input  logic                  hmastlock_i,
    input  logic                  hready_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned MemBytes = MEM_DEPTH * 4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  accept;
    logic                  req_err;
    logic [IdxW-1:0]       idx;
    logic [3:0]            be;
    logic                  mem_we;

    // Sideband controls are accepted but have no effect on decoding.
    logic unused_inputs;
    assign unused_inputs = ^{hbrust_i, hport_i, hmastlock_i, htrans_i[0], addr_q};

    assign accept = hselx_i & hready_i & htrans_i[1];
    assign idx    = addr_q[IdxW+1:2];
    assign mem_we = (state_q == StAccess) && write_q;

    // Classify the transfer currently in its address phase.
    always_comb begin
        req_err = 1'b0;
        if (32'(haddr_i) >= MemBytes) begin
            req_err = 1'b1;
        end
        case (hsize_i)
            3'd0:    ;
            3'd1:    if (haddr_i[0]) req_err = 1'b1;
            3'd2:    if (haddr_i[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Byte lanes touched by the registered transfer.
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Next-state, address-phase capture and bus response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        hrdata_o    = '0;

        unique case (state_q)
            StIdle:   ;
            StWait:   hreadyout_o = 1'b0;
            StAccess: hrdata_o = mem_q[idx];
            StErr1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
            end
            StErr2:   hresp_o = 1'b1;
            default:  ;
        endcase

        unique case (state_q)
            StIdle, StAccess, StErr2: begin
                if (accept) begin
                    addr_d  = haddr_i;
                    write_d = hwrite_i;
                    size_d  = hsize_i[1:0];
                    if (req_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // Control state; a reset abandons any pending transfer.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Commit write data on the edge that closes the ACCESS cycle.
    always_ff @(posedge hclk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][i*8 +: 8] <= hwdata_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB-Lite slave memory, directly downstream of the testbench AHB bus interface.
- Decodes address/control phases, stores write data in an internal word array and returns read data.
- Drives hreadyout/hresp with configurable wait states and the two-cycle ERROR response.
- This is the DUT the driver and monitor clocking blocks connect to.

Parameters:
ADDR_WIDTH, 16, byte address width of haddr
DATA_WIDTH, 32, data bus width (fixed 32; other values unsupported)
MEM_DEPTH, 1024, number of 32-bit words in the array
WAIT_STATES, 0, extra low-hreadyout cycles inserted in every OKAY data phase (0..15)

Ports:
hclk  in  1  clock; all state updates on rising edge
hresetn  in  1  reset; asynchronous, active-low
hselx  in  1  slave select
haddr  in  ADDR_WIDTH  byte address
htrans  in  2  0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
hwrite  in  1  1=write 0=read
hsize  in  3  0=byte 1=half 2=word
hbrust  in  3  burst type; accepted, not interpreted
hport  in  4  protection; accepted, not interpreted
hmastlock  in  1  accepted, not interpreted
hready  in  1  bus ready (previous transfer complete)
hwdata  in  32  write data (data phase)
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY 1=ERROR

Behaviour:
- Reset (hresetn low, async): state=IDLE, hreadyout=1, hresp=0, hrdata=0, pending transfer discarded. Memory array is not reset.
- Reset mid-transfer: an in-flight write is not committed.
- Address phase accepted on a rising edge when hselx & hready & htrans[1]. Register addr, hwrite and hsize.
- IDLE/BUSY with hselx: zero-wait OKAY (hreadyout=1, hresp=0), no access.
- Error check at accept. A transfer is an error if any of these holds:
  - haddr >= MEM_DEPTH*4
  - hsize > 2
  - misaligned: half with haddr[0]=1; word with haddr[1:0]!=0
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0; counter loads WAIT_STATES and decrements.
  - ACCESS: hreadyout=1, hresp=0; final data cycle.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions on accept:
  - error transfer -> ERR1 -> ERR2;
  - else WAIT_STATES=0 -> ACCESS;
  - else -> WAIT, then ACCESS after WAIT_STATES cycles.
- From ACCESS/ERR2: new accept -> same rules; else -> IDLE.
- During WAIT/ERR1, hready is low, so no accept occurs.
- Write commit: at the rising edge ending ACCESS, hwdata is written with byte enables from registered hsize/addr[1:0]:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - Unselected bytes are unchanged. ERROR transfers never write.
- Read: hrdata = full word mem[addr>>2] during ACCESS; the master selects lanes. hrdata=0 in all other states. Read is combinational from the registered address.
- Back-to-back write then read of the same word (pipelined): the read returns the newly written bytes. The commit precedes the read data phase.
- hbrust/hport/hmastlock have no effect; each beat is decoded independently.
- hselx low with htrans active: ignored; state and outputs unchanged.

Test Plan:
- Reset: assert hresetn=0 mid-WAIT (WAIT_STATES=2) -> immediately hreadyout=1, hresp=0, hrdata=0; the pending write to 0x0010 is not stored.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF @0x0004, then read @0x0004 pipelined -> hreadyout never low; hrdata=0xDEADBEEF in the read data phase.
- Subword: word write 0x11223344 @0x0008, byte write 0xAA @0x000A, half write 0xBBCC @0x0008, read word -> 0x11AABBCC.
- Wait states, WAIT_STATES=3: read @0x0000 -> hreadyout low exactly 3 cycles, then high with data; the next address phase is accepted only in the ACCESS cycle.
- Errors:
  - word read @0x0002 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1);
  - write @0x1000 (MEM_DEPTH=1024) -> same ERROR sequence, array unchanged;
  - hsize=3 -> ERROR.
- IDLE/BUSY: hselx=1, htrans=1 between SEQ beats -> OKAY zero-wait, no memory access; the following SEQ completes normally.
